// File: rtl/lsl_pipe_pkg.sv
// Shared helpers for the pipelined logarithmic left shifter: log2 sizing and
// the parameter legality check used at elaboration.
package lsl_pipe_pkg;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // WIDTH must be a power of two (>= 2) and LOGW its exact log2.
    function automatic bit lsl_params_ok(input int width, input int logw);
        return (width >= 2) && ((width & (width - 1)) == 0) && (logw == clog2(width));
    endfunction

endpackage

// File: rtl/lsl_stage.sv
// One power-of-two shift stage with a one-slot valid/ready register slice.
// Shift amount arrives right-aligned; bit 0 selects this stage's shift.
module lsl_stage
    import lsl_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHIFT = 1,
    parameter int SW    = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_d,
    input  logic [SW-1:0]    src_s,
    input  logic             src_c,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_d,
    output logic [SW-1:0]    dst_s,
    output logic             dst_c
);

    logic             load;
    logic [WIDTH-1:0] next_d;
    logic [SW-1:0]    next_s;
    logic             next_c;

    // The slot may refill when it is empty or when its content leaves this cycle.
    assign load      = !dst_valid || dst_ready;
    assign src_ready = ASYNCRESETN && load;

    always_comb begin
        next_d = src_d;
        next_c = src_c;
        next_s = src_s >> 1;
        if (src_s[0]) begin
            next_d = src_d << SHIFT;
            next_c = src_c | (|src_d[WIDTH-1 -: SHIFT]);
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            dst_valid <= 1'b0;
            dst_d     <= '0;
            dst_s     <= '0;
            dst_c     <= 1'b0;
        end else begin
            if (load) begin
                dst_valid <= src_valid;
            end
            // Payload only moves with a real operand so empty slots never pick up junk.
            if (load && src_valid) begin
                dst_d <= next_d;
                dst_s <= next_s;
                dst_c <= next_c;
            end
        end
    end

endmodule

// File: rtl/lsl_pipe.sv
// Registered, flow-controlled logarithmic left shifter: LOGW shift stages,
// each followed by a register slice, one operation per cycle.
module lsl_pipe
    import lsl_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LOGW  = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I,
    input  logic [LOGW-1:0]  S,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             C
);

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [LOGW-1:0]  s;
        logic             c;
    } stage_t;

    generate
        if (!lsl_params_ok(WIDTH, LOGW)) begin : g_bad_params
            $error("lsl_pipe: WIDTH must be a power of two >= 2 and LOGW must equal log2(WIDTH)");
        end
    endgenerate

    // Index k is the input of stage k; index LOGW is the output of the last stage.
    stage_t slot  [LOGW+1];
    logic   valid [LOGW+1];
    logic   ready [LOGW+1];

    assign slot[0]     = '{d: I, s: S, c: 1'b0};
    assign valid[0]    = I_VALID;
    assign I_READY     = ready[0];
    assign ready[LOGW] = O_READY;

    // Ready ripples combinationally from the output back to the input, so a full
    // pipe accepts and emits in the same cycle without bubbles.
    for (genvar k = 0; k < LOGW; k++) begin : g_stage
        lsl_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k),
            .SW    (LOGW)
        ) u_stage (
            .CLK         (CLK),
            .ASYNCRESETN (ASYNCRESETN),
            .src_valid   (valid[k]),
            .src_ready   (ready[k]),
            .src_d       (slot[k].d),
            .src_s       (slot[k].s),
            .src_c       (slot[k].c),
            .dst_valid   (valid[k+1]),
            .dst_ready   (ready[k+1]),
            .dst_d       (slot[k+1].d),
            .dst_s       (slot[k+1].s),
            .dst_c       (slot[k+1].c)
        );
    end

    assign O_VALID = valid[LOGW];
    assign O       = slot[LOGW].d;
    assign C       = slot[LOGW].c;

endmodule

// File: tb/tb_lsl_pipe.sv
// Bench for lsl_pipe: directed WIDTH=4 scenarios plus a randomized WIDTH=8 run,
// both scored against an expected-result queue.
module tb_lsl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       v4, r4, ov4, or4, c4;
    logic [3:0] i4, o4;
    logic [1:0] s4;
    logic       v8, r8, ov8, or8, c8;
    logic [7:0] i8, o8;
    logic [2:0] s8;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in4 = 0, n_out4 = 0, n_in8 = 0, n_out8 = 0;
    logic [4:0] exp_q4[$];
    logic [8:0] exp_q8[$];
    logic [4:0] e4;
    logic [8:0] e8;

    lsl_pipe #(.WIDTH(4), .LOGW(2)) u_dut4 (
        .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(v4), .I_READY(r4), .I(i4), .S(s4),
        .O_VALID(ov4), .O_READY(or4), .O(o4), .C(c4)
    );

    lsl_pipe #(.WIDTH(8), .LOGW(3)) u_dut8 (
        .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(v8), .I_READY(r8), .I(i8), .S(s8),
        .O_VALID(ov8), .O_READY(or8), .O(o8), .C(c8)
    );

    function automatic logic [4:0] model4(input logic [3:0] d, input logic [1:0] sh);
        logic [7:0] wide;
        wide = {4'b0, d} << sh;
        return {|wide[7:4], wide[3:0]};
    endfunction

    function automatic logic [8:0] model8(input logic [7:0] d, input logic [2:0] sh);
        logic [15:0] wide;
        wide = {8'b0, d} << sh;
        return {|wide[15:8], wide[7:0]};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on emitted output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (v4 && r4) begin
                exp_q4.push_back(model4(i4, s4));
                n_in4++;
            end
            if (ov4 && or4) begin
                n_checks++;
                n_out4++;
                if (exp_q4.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb4_unexpected: got o=%b c=%b, required no output", o4, c4);
                end else begin
                    e4 = exp_q4.pop_front();
                    if ({c4, o4} !== e4) begin
                        n_fail++;
                        $display("FAIL sb4_result: got c=%b o=%b, required c=%b o=%b", c4, o4, e4[4], e4[3:0]);
                    end
                end
            end
            if (v8 && r8) begin
                exp_q8.push_back(model8(i8, s8));
                n_in8++;
            end
            if (ov8 && or8) begin
                n_checks++;
                n_out8++;
                if (exp_q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb8_unexpected: got o=%h c=%b, required no output", o8, c8);
                end else begin
                    e8 = exp_q8.pop_front();
                    if ({c8, o8} !== e8) begin
                        n_fail++;
                        $display("FAIL sb8_result: got c=%b o=%h, required c=%b o=%h", c8, o8, e8[8], e8[7:0]);
                    end
                end
            end
        end
    end

    task automatic send4(input logic [3:0] d, input logic [1:0] sh);
        int waited;
        waited = 0;
        v4 = 1'b1;
        i4 = d;
        s4 = sh;
        @(negedge clk);
        while (!r4 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (r4 !== 1'b1) begin
            n_fail++;
            $display("FAIL send4_timeout: i_ready=%b after %0d cycles, required 1", r4, waited);
        end
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic wait_drain4();
        int waited;
        waited = 0;
        or4 = 1'b1;
        while ((exp_q4.size() != 0 || ov4) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (exp_q4.size() != 0 || n_in4 != n_out4) begin
            n_fail++;
            $display("FAIL drain4: pending=%0d in=%0d out=%0d, required 0 pending and in==out",
                     exp_q4.size(), n_in4, n_out4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v4 = 1'b0; i4 = '0; s4 = '0; or4 = 1'b0;
        v8 = 1'b0; i8 = '0; s8 = '0; or8 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ov4, o4, c4} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_out4: got v=%b o=%b c=%b, required all 0", ov4, o4, c4);
        end
        n_checks++;
        if (r4 !== 1'b0 || r8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_iready: got %b/%b, required 0/0", r4, r8);
        end
        n_checks++;
        if ({ov8, o8, c8} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_out8: got v=%b o=%h c=%b, required all 0", ov8, o8, c8);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (r4 !== 1'b1 || r8 !== 1'b1 || ov4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got i_ready=%b/%b o_valid=%b, required 1/1 0", r4, r8, ov4);
        end
    endtask

    task automatic test_stream();
        logic [3:0] st_o [4] = '{4'b1011, 4'b0110, 4'b1100, 4'b1000};
        logic       st_c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        @(posedge clk);
        #1;
        or4 = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) send4(4'b1011, 2'(k));
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!ov4 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
                    if (ov4 !== 1'b1 || o4 !== st_o[k] || c4 !== st_c[k]) begin
                        n_fail++;
                        $display("FAIL stream_%0d: got v=%b o=%b c=%b, required v=1 o=%b c=%b",
                                 k, ov4, o4, c4, st_o[k], st_c[k]);
                    end
                    @(negedge clk);
                end
            end
        join
        wait_drain4();
    endtask

    task automatic test_backpressure();
        int base;
        @(posedge clk);
        #1;
        or4 = 1'b0;
        base = n_in4;
        fork
            begin
                send4(4'b0001, 2'd1);
                send4(4'b0001, 2'd2);
                send4(4'b0001, 2'd3);
            end
            begin
                int w;
                w = 0;
                while (n_in4 < base + 2 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (r4 !== 1'b0 || ov4 !== 1'b1 || o4 !== 4'b0010 || c4 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL bp_hold_%0d: got i_ready=%b v=%b o=%b c=%b, required 0 1 0010 0",
                                 k, r4, ov4, o4, c4);
                    end
                end
                @(posedge clk);
                #1;
                or4 = 1'b1;
            end
        join
        wait_drain4();
    endtask

    task automatic test_back_to_back();
        int base_in, base_out;
        @(posedge clk);
        #1;
        or4 = 1'b1;
        base_in  = n_in4;
        base_out = n_out4;
        fork
            begin
                for (int k = 0; k < 8; k++) send4(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end
            begin
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    or4 = ~or4;
                end
            end
            begin
                repeat (16) begin
                    @(negedge clk);
                    if (ov4 && or4) begin
                        n_checks++;
                        if (r4 !== 1'b1) begin
                            n_fail++;
                            $display("FAIL b2b_ready_mirror: got i_ready=%b while draining, required 1", r4);
                        end
                    end
                end
            end
        join
        wait_drain4();
        n_checks++;
        if (n_in4 - base_in != 8 || n_out4 - base_out != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got in=%0d out=%0d, required 8/8", n_in4 - base_in, n_out4 - base_out);
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk);
        #1;
        or4 = 1'b0;
        send4(4'b0001, 2'd1);
        send4(4'b0001, 2'd2);
        @(negedge clk);
        n_checks++;
        if (ov4 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inflight: got o_valid=%b, required 1", ov4);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov4, o4, c4, r4} !== 7'b0) begin
            n_fail++;
            $display("FAIL mid_reset_now: got v=%b o=%b c=%b i_ready=%b, required all 0", ov4, o4, c4, r4);
        end
        exp_q4.delete();
        exp_q8.delete();
        n_in4 = 0; n_out4 = 0; n_in8 = 0; n_out8 = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        or4 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (ov4 !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale: got o_valid=%b o=%b, required 0", ov4, o4);
            end
        end
        @(posedge clk);
        #1;
        fork
            send4(4'b0011, 2'd1);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!ov4 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                n_checks++;
                if (ov4 !== 1'b1 || o4 !== 4'b0110 || c4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_first_op: got v=%b o=%b c=%b, required 1 0110 0", ov4, o4, c4);
                end
            end
        join
        wait_drain4();
    endtask

    task automatic test_random8();
        int cyc;
        int pick;
        int w;
        cyc = 0;
        @(posedge clk);
        #1;
        while (n_in8 < 10000 && cyc < 60000) begin
            pick = $urandom_range(0, 7);
            v8   = ($urandom_range(0, 3) != 0);
            i8   = 8'($urandom);
            s8   = 3'($urandom_range(0, 7));
            if (pick == 0) s8 = 3'd0;
            if (pick == 1) i8 = 8'hFF;
            if (pick == 2) s8 = 3'd7;
            or8 = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        v8  = 1'b0;
        or8 = 1'b1;
        w   = 0;
        while ((exp_q8.size() != 0 || ov8) && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (n_in8 < 10000 || exp_q8.size() != 0 || n_in8 != n_out8) begin
            n_fail++;
            $display("FAIL random8: got in=%0d out=%0d pending=%0d, required in>=10000 and in==out",
                     n_in8, n_out8, exp_q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
